// File: rtl/buffer_write_arbiter_pkg.sv
// Shared definitions for the buffer write-port arbiter:
// FSM state encoding, default sizing and an index-width helper.
package buf_arb_pkg;

  localparam int DEF_N_REQ     = 4;
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_MAX_BURST = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_t;

  // Bits needed to hold an index in 0..value-1 (value >= 2).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/buffer_write_arbiter_rr_pick.sv
// Rotating priority encoder: returns the first requester with req set,
// scanning upward from base and wrapping modulo N_REQ. Purely combinational.
module rr_pick
  import buf_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IDX_W = clog2(DEF_N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] base,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // cand[k] is the requester index k places after base (mod N_REQ).
  logic [IDX_W-1:0] cand [N_REQ];
  logic [N_REQ-1:0] hit;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
    logic [IDX_W:0] sum;
    // Explicit compare-and-subtract keeps the wrap correct for any N_REQ.
    assign sum       = {1'b0, base} + (IDX_W + 1)'(gi);
    assign cand[gi]  = (sum >= (IDX_W + 1)'(N_REQ)) ? IDX_W'(sum - (IDX_W + 1)'(N_REQ))
                                                     : sum[IDX_W-1:0];
    assign hit[gi]   = req[cand[gi]];
  end

  // Lowest rotation offset with a pending request wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (hit[k]) begin
        found = 1'b1;
        idx   = cand[k];
      end
    end
  end

endmodule

// File: rtl/buffer_write_arbiter.sv
// Round-robin arbiter sharing the word buffer's write port among N_REQ
// requesters. One owner at a time forwards up to MAX_BURST words, stalling
// on buffer_full; ownership rotates on burst end or when the owner goes idle.
module buffer_write_arbiter
  import buf_arb_pkg::*;
#(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                     clk_1,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*DATA_W-1:0]  data_in,
  output logic [N_REQ-1:0]         ack,
  input  logic                     buffer_full,
  output logic                     data_1_en,
  output logic [DATA_W-1:0]        data_1,
  output logic [clog2(N_REQ)-1:0]  grant_id,
  output logic                     busy
);

  localparam int IDX_W = clog2(N_REQ);

  arb_state_t       state_reg;
  logic [IDX_W-1:0] owner_reg;
  logic [IDX_W-1:0] rr_ptr_reg;
  logic [3:0]       burst_cnt_reg;

  logic [DATA_W-1:0] words [N_REQ];
  logic [IDX_W-1:0]  owner_inc;
  logic [IDX_W-1:0]  pick_base;
  logic              pick_found;
  logic [IDX_W-1:0]  pick_idx;
  logic              in_burst;
  logic              owner_req;
  logic              accept;
  logic              last_beat;
  logic              release_now;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_words
    assign words[gi] = data_in[gi*DATA_W +: DATA_W];
  end

  assign in_burst  = (state_reg == ST_BURST);
  assign owner_inc = (owner_reg == IDX_W'(N_REQ - 1)) ? '0 : owner_reg + 1'b1;
  // In IDLE the pick starts at rr_ptr; on a release it starts just past the
  // outgoing owner, which is exactly the rr_ptr value being written.
  assign pick_base = in_burst ? owner_inc : rr_ptr_reg;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (req),
    .base  (pick_base),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign owner_req   = req[owner_reg];
  // rst gates accept so no word is consumed in a cycle that resets the FSM.
  assign accept      = in_burst & ~rst & owner_req & ~buffer_full;
  assign last_beat   = (burst_cnt_reg == 4'(MAX_BURST - 1));
  assign release_now = in_burst & (~owner_req | (accept & last_beat));

  assign data_1_en = accept;
  assign grant_id  = owner_reg;
  assign busy      = in_burst;

  // Forward the owner's word only when it is actually accepted.
  always_comb begin
    ack    = '0;
    data_1 = '0;
    if (accept) begin
      ack[owner_reg] = 1'b1;
      data_1         = words[owner_reg];
    end
  end

  // Grant FSM: pick, count accepted beats, rotate on release.
  always_ff @(posedge clk_1) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      owner_reg     <= '0;
      rr_ptr_reg    <= '0;
      burst_cnt_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (pick_found) begin
            owner_reg     <= pick_idx;
            burst_cnt_reg <= '0;
            state_reg     <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (release_now) begin
            rr_ptr_reg    <= owner_inc;
            burst_cnt_reg <= '0;
            if (pick_found) begin
              owner_reg <= pick_idx;
            end else begin
              state_reg <= ST_IDLE;
            end
          end else if (accept) begin
            burst_cnt_reg <= burst_cnt_reg + 4'd1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_buffer_write_arbiter.sv
// Bench for buffer_write_arbiter: directed scenarios with literal expectations
// plus a randomized phase, all cross-checked every cycle by a behavioural model.
`timescale 1ns/1ps
module tb_buffer_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int MB = 4;
  localparam int IW = 2;

  logic          clk_1 = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N*DW-1:0] data_in = '0;
  logic [N-1:0]  ack;
  logic          buffer_full = 1'b0;
  logic          data_1_en;
  logic [DW-1:0] data_1;
  logic [IW-1:0] grant_id;
  logic          busy;

  buffer_write_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk_1       (clk_1),
    .rst         (rst),
    .req         (req),
    .data_in     (data_in),
    .ack         (ack),
    .buffer_full (buffer_full),
    .data_1_en   (data_1_en),
    .data_1      (data_1),
    .grant_id    (grant_id),
    .busy        (busy)
  );

  always #5 clk_1 = ~clk_1;

  int checks = 0;
  int failures = 0;

  // Requester sources: word presented by i is base_word[i] + seq[i].
  logic [DW-1:0] base_word [N];
  int            seq [N];
  int            lim [N];
  logic [N-1:0]  acked_mask = '0;

  // Model state: who owns the port, rotation pointer, accepted beats.
  bit m_busy = 1'b0;
  int m_owner = 0;
  int m_ptr = 0;
  int m_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_data();
    for (int i = 0; i < N; i++) data_in[i*DW +: DW] = base_word[i] + DW'(seq[i]);
  endtask

  function automatic int first_from(input logic [N-1:0] r, input int b);
    for (int k = 0; k < N; k++) if (r[(b + k) % N]) return (b + k) % N;
    return -1;
  endfunction

  // Behavioural model and per-cycle comparison against the DUT.
  always @(negedge clk_1) begin : model_cmp
    bit acc;
    logic [N-1:0] e_ack;
    logic [DW-1:0] e_data;
    int p;
    acc = !rst && m_busy && req[m_owner] && !buffer_full;
    e_ack = '0;
    e_data = '0;
    if (acc) begin
      e_ack[m_owner] = 1'b1;
      e_data = base_word[m_owner] + DW'(seq[m_owner]);
    end
    chk("model_ack", ack, e_ack);
    chk("model_en", data_1_en, acc);
    chk("model_data", data_1, e_data);
    chk("model_grant", grant_id, m_owner);
    chk("model_busy", busy, m_busy);
    acked_mask = e_ack;
    if (rst) begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
    end else if (!m_busy) begin
      p = first_from(req, m_ptr);
      if (p >= 0) begin m_busy = 1; m_owner = p; m_cnt = 0; end
    end else if (!req[m_owner] || (acc && m_cnt == MB - 1)) begin
      m_ptr = (m_owner + 1) % N;
      p = first_from(req, m_ptr);
      m_cnt = 0;
      if (p >= 0) m_owner = p;
      else m_busy = 0;
    end else if (acc) begin
      m_cnt++;
    end
  end

  // Advance one clock; consumed words move their source to the next word.
  task automatic tick();
    @(posedge clk_1);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acked_mask[i]) begin
        seq[i]++;
        if (seq[i] >= lim[i]) req[i] = 1'b0;
      end
    end
    drive_data();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    req = '0;
    buffer_full = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_1);
      chk("rst_ack", ack, 0);
      chk("rst_en", data_1_en, 0);
      chk("rst_data", data_1, 0);
      tick();
    end
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin seq[i] = 0; lim[i] = 1 << 30; end
    drive_data();
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin base_word[i] = '0; seq[i] = 0; lim[i] = 1 << 30; end
    drive_data();

    // Reset then idle.
    do_reset(3);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_1);
      chk("idle_busy", busy, 0);
      chk("idle_grant", grant_id, 0);
      chk("idle_ack", ack, 0);
      chk("idle_en", data_1_en, 0);
      tick();
    end

    // Single requester: 10 words back to back, grant stays on 2.
    base_word[2] = 16'hA000; lim[2] = 10; drive_data();
    req = 4'b0100;
    @(negedge clk_1);
    chk("single_first_noack", ack, 0);
    tick();
    for (int j = 0; j < 10; j++) begin
      @(negedge clk_1);
      chk("single_ack", ack, 4'b0100);
      chk("single_en", data_1_en, 1);
      chk("single_data", data_1, 32'(16'hA000 + j));
      chk("single_grant", grant_id, 2);
      tick();
    end
    @(negedge clk_1);
    chk("single_done_ack", ack, 0);
    tick(); tick();

    // Fair rotation with all four requesting.
    do_reset(1);
    for (int i = 0; i < N; i++) base_word[i] = DW'(16'h1000 * (i + 1));
    drive_data();
    req = 4'b1111;
    @(negedge clk_1);
    chk("rot_idle_ack", ack, 0);
    tick();
    for (int n = 0; n < 32; n++) begin
      int o;
      o = (n / 4) % 4;
      @(negedge clk_1);
      chk("rot_ack", ack, 32'(1 << o));
      chk("rot_data", data_1, 32'(16'h1000 * (o + 1) + (n / 16) * 4 + n % 4));
      chk("rot_grant", grant_id, o);
      tick();
    end
    req = '0;
    tick(); tick();

    // Backpressure on owner 1.
    do_reset(1);
    base_word[1] = 16'hB000; lim[1] = 4; drive_data();
    req = 4'b0010;
    @(negedge clk_1);
    tick();
    for (int j = 0; j < 2; j++) begin
      @(negedge clk_1);
      chk("bp_pre_ack", ack, 4'b0010);
      chk("bp_pre_data", data_1, 32'(16'hB000 + j));
      tick();
    end
    buffer_full = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk_1);
      chk("bp_stall_ack", ack, 0);
      chk("bp_stall_en", data_1_en, 0);
      chk("bp_stall_grant", grant_id, 1);
      chk("bp_stall_busy", busy, 1);
      tick();
    end
    buffer_full = 1'b0;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk_1);
      chk("bp_post_ack", ack, 4'b0010);
      chk("bp_post_data", data_1, 32'(16'hB002 + j));
      tick();
    end
    @(negedge clk_1);
    chk("bp_end_ack", ack, 0);
    tick();
    @(negedge clk_1);
    chk("bp_end_busy", busy, 0);
    tick();

    // Early release: requester 0 quits after two words, 3 takes over.
    do_reset(1);
    base_word[0] = 16'hC000; base_word[3] = 16'hD000; lim[0] = 2; drive_data();
    req = 4'b1001;
    @(negedge clk_1);
    tick();
    for (int j = 0; j < 2; j++) begin
      @(negedge clk_1);
      chk("early_ack0", ack, 4'b0001);
      chk("early_data0", data_1, 32'(16'hC000 + j));
      tick();
    end
    @(negedge clk_1);
    chk("early_gap_ack", ack, 0);
    tick();
    @(negedge clk_1);
    chk("early_grant3", grant_id, 3);
    chk("early_ack3", ack, 4'b1000);
    chk("early_data3", data_1, 32'hD000);
    tick();
    req = '0;
    tick(); tick();

    // Reset during owner 2's third word.
    do_reset(1);
    base_word[2] = 16'hE000; drive_data();
    req = 4'b0100;
    @(negedge clk_1);
    tick();
    for (int j = 0; j < 2; j++) begin
      @(negedge clk_1);
      chk("mrst_pre_ack", ack, 4'b0100);
      tick();
    end
    rst = 1'b1;
    @(negedge clk_1);
    chk("mrst_ack", ack, 0);
    chk("mrst_en", data_1_en, 0);
    tick();
    rst = 1'b0;
    @(negedge clk_1);
    chk("mrst_busy", busy, 0);
    chk("mrst_idle_ack", ack, 0);
    tick();
    for (int j = 0; j < 4; j++) begin
      @(negedge clk_1);
      chk("mrst_burst_ack", ack, 4'b0100);
      chk("mrst_burst_data", data_1, 32'(16'hE002 + j));
      chk("mrst_burst_grant", grant_id, 2);
      tick();
    end
    req = '0;
    tick(); tick();

    // Randomized traffic, full flag and occasional reset; model checks all.
    do_reset(2);
    for (int i = 0; i < N; i++) base_word[i] = DW'($urandom);
    drive_data();
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst = ($urandom_range(0, 199) == 0);
      buffer_full = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if (!acked_mask[i] && $urandom_range(0, 19) == 0) req[i] = 1'b0;
          else if (acked_mask[i] && $urandom_range(0, 3) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
        end
      end
    end
    rst = 1'b0;
    req = '0;
    buffer_full = 1'b0;
    tick(); tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/buffer_write_arbiter.md
# buffer_write_arbiter

Round-robin write-port arbiter in the clk_1 domain that shares the producer side of the 8-entry dual-clock word buffer among N_REQ requesters. It grants one requester at a time for a bounded burst and forwards that requester's words onto the buffer's data_1/data_1_en write port. Forwarding honours buffer_full, so no word is ever presented while the buffer is full. It sits directly in front of the buffer; the clk_2 read side is untouched.

## Interface
- N_REQ, 4, number of requesters (2..8)
- DATA_W, 16, word width; must match the buffer data width
- MAX_BURST, 4, max words accepted per grant before forced rotation (1..15)

- clk_1  in  1  write-domain clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- req  in  N_REQ  per-requester word-valid; held high with data stable until acked
- data_in  in  N_REQ*DATA_W  packed words, requester i at bits [i*DATA_W +: DATA_W]
- ack  out  N_REQ  one-hot; ack[i]=1 means requester i's word is consumed at this edge
- buffer_full  in  1  buffer full flag (clk_1-valid)
- data_1_en  out  1  buffer write enable
- data_1  out  DATA_W  buffer write data
- grant_id  out  clog2(N_REQ)  current owner index (registered)
- busy  out  1  1 while state is BURST

## Operation
- States: IDLE, BURST. Registers: state, owner, rr_ptr (highest-priority index), burst_cnt.
- Pick: rotating priority starting at rr_ptr, ascending modulo N_REQ; first i with req[i]=1 wins.
- IDLE:
  - If any req is high, at the edge: owner<=pick, burst_cnt<=0, state<=BURST.
  - Otherwise stay in IDLE.
  - ack=0 in IDLE.
- BURST:
  - Accept condition: accept = req[owner] & ~buffer_full.
  - ack[owner]=accept; data_1_en=accept; data_1=data_in[owner] (combinational).
  - All other ack bits are 0.
  - On accept: burst_cnt++.
- Release occurs on either of:
  - (a) req[owner]=0;
  - (b) accept with burst_cnt==MAX_BURST-1.
- On release:
  - rr_ptr<=owner+1 (mod N_REQ).
  - If any req is high, re-pick immediately from the new rr_ptr: owner<=that pick, burst_cnt<=0, stay in BURST (no bubble). Otherwise state<=IDLE.
  - The re-pick sees the current req vector, so the old owner may win again if it is the only requester.
- Stall: buffer_full=1 with req[owner]=1 gives ack=0 and no count change. The grant is held and stall cycles do not count toward MAX_BURST.
- When not accepting, data_1 is forced to 0. data_1 never carries an unacked word with data_1_en=1.
- Width rules:
  - burst_cnt is 4 bits.
  - rr_ptr/owner wrap modulo N_REQ; for non-power-of-two N_REQ, explicit compare-and-reset is required.

## Timing
- Reset values: state=IDLE, owner=0, rr_ptr=0, burst_cnt=0, grant_id=0, busy=0. With state=IDLE, combinational ack=0, data_1_en=0, data_1=0.
- Latency: req rising in IDLE at edge k gives grant at k+1; first ack is in cycle k+1, with the word written at edge k+2.
- Throughput: 1 word/cycle while not full, including across owner switches.
- Simultaneous buffer_full=1 and req[owner]=0 is treated as a release (a).
- buffer_full rising mid-burst stops ack in that same cycle; there is no in-flight word.
- Reset mid-burst returns to IDLE at the next edge, with no ack in the cycle rst is sampled high. An unacked requester word stays pending at its source.
- Requester contract: data_in slice stable while req high. Dropping req without ack abandons the word, with no side effect.

## Structure
- Shared package buf_arb_pkg: state encoding (ST_IDLE=0, ST_BURST=1), default N_REQ/DATA_W/MAX_BURST, clog2 helper.
- One sub-module: rr_pick (inputs req vector and base pointer; outputs found flag and index; purely combinational rotating priority encoder).
- Top-level holds the FSM, counters and output mux.

## Test plan
- Reset then idle: rst 3 cycles, req=0 -> ack=0, data_1_en=0, data_1=0, busy=0, grant_id=0 throughout.
- Single requester: req[2]=1 with words 0xA000..0xA009, buffer never full -> first ack one cycle after req. Words are written in order. After each 4 words, grant_id stays 2 with no bubble, and 10 consecutive data_1_en pulses occur.
- Fair rotation: req=4'b1111 continuously -> grant order 0,1,2,3,0..., exactly 4 acks each per turn, and data_1 matches each source's word sequence.
- Backpressure: owner 1 mid-burst, buffer_full=1 for 5 cycles -> ack=0 and data_1_en=0 for those 5 cycles, grant held. After buffer_full falls, the remaining words of the 4-word burst complete.
- Early release: req[0] drops after 2 acks while req[3]=1 -> next cycle grant_id=3 and ack[3]=1, rr_ptr advanced past 0.
- Reset mid-burst: rst asserted during owner 2's third word -> no ack that cycle. busy=0 next cycle. After rst release with req=4'b0100, a fresh 4-word burst is issued starting from rr_ptr=0 priority.
